ps2_key_ctrl: RTL and testbench
===============================

PS2_KEY_CTRL -- requirements
Module: ps2_key_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 5_000_000, meaning max CLOCK_50 cycles allowed between bytes of one multi-byte sequence (100 ms at 50 MHz).
REQ-002 Port CLOCK_50  input  1  sole clock, all logic on rising edge.
REQ-003 Port resetn  input  1  reset, synchronous, active-low.
REQ-004 Port scan_code  input  8  PS/2 set-2 byte from the PS/2 interface.
REQ-005 Port scan_ready  input  1  one-cycle strobe, scan_code valid in that cycle.
REQ-006 Port p1_up, p1_down  output  1 each  player-1 paddle direction levels (W / S).
REQ-007 Port p2_up, p2_down  output  1 each  player-2 paddle direction levels (Up / Down arrows).
REQ-008 Port start_pulse  output  1  one-cycle pulse on Space press.
REQ-009 Port pause_pulse  output  1  one-cycle pulse on P press.
REQ-010 Port last_make  output  8  last completed make code, E0-extended codes reported as the second byte.
REQ-011 Port seq_timeout  output  1  one-cycle pulse when a partial sequence is abandoned.

Function
REQ-012 Decoder FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
REQ-013 Byte processing only in cycles with scan_ready=1; all other inputs ignored otherwise.
REQ-014 IDLE: E0 -> EXT; F0 -> BRK; any other byte = plain make, stay IDLE.
REQ-015 EXT: F0 -> EXT_BRK; E0 -> stay EXT; other byte = extended make -> IDLE.
REQ-016 BRK: F0 -> stay BRK; other byte = plain break -> IDLE. E0 in BRK -> EXT_BRK.
REQ-017 EXT_BRK: E0/F0 -> stay; other byte = extended break -> IDLE.
REQ-018 Held flags: plain 1D=W, 1B=S, 29=Space, 4D=P; extended 75=Up, 72=Down; make sets, break clears; all other codes ignored (no flag change).
REQ-019 p1_up = W & ~S; p1_down = S & ~W; likewise p2 with Up/Down; both held -> both outputs 0.
REQ-020 Outputs registered; effect visible the cycle after the scan_ready that completes the sequence (latency 1).
REQ-021 start_pulse/pause_pulse assert only on make when flag was clear; typematic repeat makes while held produce no pulse.
REQ-022 last_make updates on every completed make, recognised or not.
REQ-023 Timeout counter clears on each scan_ready; increments while state != IDLE; at TIMEOUT_CYCLES-1 -> IDLE, seq_timeout pulse, held flags unchanged.
REQ-024 Counter saturates-free: width ceil(log2(TIMEOUT_CYCLES)); never wraps since it clears on expiry.
REQ-025 scan_ready in the timeout cycle: byte processed in current state, no timeout.

Reset
REQ-026 resetn=0 at a clock edge: state IDLE, counter 0, all held flags 0, all outputs 0, last_make 8'h00.
REQ-027 Reset mid-sequence discards the partial sequence; a byte with scan_ready during reset is dropped.

Structure
REQ-028 Package ps2_keys_pkg holds scan-code constants (E0, F0, 1D, 1B, 29, 4D, 75, 72) and the FSM state encoding.
REQ-029 Single module; no sub-module natural.

Verification
REQ-030 Bytes 1D, then F0 1D -> p1_up=1 one cycle after first strobe, 0 one cycle after 1D following F0; last_make=1D.
REQ-031 E0 75, E0 72 -> p2_up=1 then both p2 outputs 0; E0 F0 75 -> p2_down=1.
REQ-032 29, 29, 29, F0 29, 29 -> exactly two start_pulse pulses, each one cycle.
REQ-033 E0 then no byte for TIMEOUT_CYCLES (test override 100) -> seq_timeout pulse, state IDLE; next 1D treated as plain make.
REQ-034 Hold W and S, reset low one cycle mid E0 F0 sequence -> all outputs 0; following 75 gives no change to p2 (plain code ignored).

Source files
------------

// File: rtl/ps2_keys_pkg.sv
// PS/2 set-2 scan-code constants and decoder state encoding shared by the
// keyboard controller.
package ps2_keys_pkg;

   localparam logic [7:0] KC_E0    = 8'hE0;
   localparam logic [7:0] KC_F0    = 8'hF0;
   localparam logic [7:0] KC_W     = 8'h1D;
   localparam logic [7:0] KC_S     = 8'h1B;
   localparam logic [7:0] KC_SPACE = 8'h29;
   localparam logic [7:0] KC_P     = 8'h4D;
   localparam logic [7:0] KC_UP    = 8'h75;
   localparam logic [7:0] KC_DOWN  = 8'h72;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXT     = 2'd1,
      ST_BRK     = 2'd2,
      ST_EXT_BRK = 2'd3
   } dec_state_e;

endpackage

// File: rtl/ps2_key_ctrl.sv
// PS/2 keyboard decoder for a two-player paddle game: tracks held keys,
// produces paddle direction levels, start/pause pulses and a sequence timeout.
module ps2_key_ctrl
   import ps2_keys_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 5_000_000
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic [7:0] scan_code,
   input  logic       scan_ready,
   output logic       p1_up,
   output logic       p1_down,
   output logic       p2_up,
   output logic       p2_down,
   output logic       start_pulse,
   output logic       pause_pulse,
   output logic [7:0] last_make,
   output logic       seq_timeout
);

   localparam int              CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   dec_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             w_q, w_d, s_q, s_d, up_q, up_d, dn_q, dn_d;
   logic             space_q, space_d, p_q, p_d;
   logic             p1_up_q, p1_up_d, p1_down_q, p1_down_d;
   logic             p2_up_q, p2_up_d, p2_down_q, p2_down_d;
   logic             start_q, start_d, pause_q, pause_d, tmo_q, tmo_d;
   logic [7:0]       last_make_q, last_make_d;
   logic             done_s, brk_s, ext_s;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      w_d         = w_q;
      s_d         = s_q;
      up_d        = up_q;
      dn_d        = dn_q;
      space_d     = space_q;
      p_d         = p_q;
      last_make_d = last_make_q;
      start_d     = 1'b0;
      pause_d     = 1'b0;
      tmo_d       = 1'b0;
      done_s      = 1'b0;
      brk_s       = 1'b0;
      ext_s       = 1'b0;

      // A byte arriving in the expiry cycle wins over the timeout.
      if (scan_ready) begin
         cnt_d = '0;
         case (state_q)
            ST_IDLE: begin
               if (scan_code == KC_E0)      state_d = ST_EXT;
               else if (scan_code == KC_F0) state_d = ST_BRK;
               else                         done_s  = 1'b1;
            end
            ST_EXT: begin
               if (scan_code == KC_F0)      state_d = ST_EXT_BRK;
               else if (scan_code == KC_E0) state_d = ST_EXT;
               else begin
                  done_s  = 1'b1;
                  ext_s   = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            ST_BRK: begin
               if (scan_code == KC_E0)      state_d = ST_EXT_BRK;
               else if (scan_code == KC_F0) state_d = ST_BRK;
               else begin
                  done_s  = 1'b1;
                  brk_s   = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            ST_EXT_BRK: begin
               if ((scan_code == KC_E0) || (scan_code == KC_F0)) begin
                  state_d = ST_EXT_BRK;
               end else begin
                  done_s  = 1'b1;
                  ext_s   = 1'b1;
                  brk_s   = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end else if (state_q != ST_IDLE) begin
         if (cnt_q == CNT_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            tmo_d   = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         cnt_d = '0;
      end

      // Completed sequence: update held flags; pulses only on a fresh press.
      if (done_s) begin
         if (!ext_s) begin
            case (scan_code)
               KC_W:     w_d = !brk_s;
               KC_S:     s_d = !brk_s;
               KC_SPACE: begin
                  start_d = !brk_s && !space_q;
                  space_d = !brk_s;
               end
               KC_P: begin
                  pause_d = !brk_s && !p_q;
                  p_d     = !brk_s;
               end
               default: ;
            endcase
         end else begin
            case (scan_code)
               KC_UP:   up_d = !brk_s;
               KC_DOWN: dn_d = !brk_s;
               default: ;
            endcase
         end
         if (!brk_s) begin
            last_make_d = scan_code;
         end
      end

      p1_up_d   = w_d  & ~s_d;
      p1_down_d = s_d  & ~w_d;
      p2_up_d   = up_d & ~dn_d;
      p2_down_d = dn_d & ~up_d;
   end

   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         w_q         <= 1'b0;
         s_q         <= 1'b0;
         up_q        <= 1'b0;
         dn_q        <= 1'b0;
         space_q     <= 1'b0;
         p_q         <= 1'b0;
         p1_up_q     <= 1'b0;
         p1_down_q   <= 1'b0;
         p2_up_q     <= 1'b0;
         p2_down_q   <= 1'b0;
         start_q     <= 1'b0;
         pause_q     <= 1'b0;
         tmo_q       <= 1'b0;
         last_make_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         w_q         <= w_d;
         s_q         <= s_d;
         up_q        <= up_d;
         dn_q        <= dn_d;
         space_q     <= space_d;
         p_q         <= p_d;
         p1_up_q     <= p1_up_d;
         p1_down_q   <= p1_down_d;
         p2_up_q     <= p2_up_d;
         p2_down_q   <= p2_down_d;
         start_q     <= start_d;
         pause_q     <= pause_d;
         tmo_q       <= tmo_d;
         last_make_q <= last_make_d;
      end
   end

   assign p1_up       = p1_up_q;
   assign p1_down     = p1_down_q;
   assign p2_up       = p2_up_q;
   assign p2_down     = p2_down_q;
   assign start_pulse = start_q;
   assign pause_pulse = pause_q;
   assign last_make   = last_make_q;
   assign seq_timeout = tmo_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Scoreboard bench for ps2_key_ctrl: a prefix/held-key reference model queues
// expected outputs per byte; a negedge monitor pops and compares.
module tb_ps2_key_ctrl;

   localparam int T = 100;

   logic       clk = 1'b0;
   logic       resetn, scan_ready;
   logic [7:0] scan_code;
   logic       p1_up, p1_down, p2_up, p2_down, start_pulse, pause_pulse, seq_timeout;
   logic [7:0] last_make;

   always #5 clk = ~clk;

   ps2_key_ctrl #(.TIMEOUT_CYCLES(T)) dut (
      .CLOCK_50(clk), .resetn(resetn), .scan_code(scan_code), .scan_ready(scan_ready),
      .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
      .start_pulse(start_pulse), .pause_pulse(pause_pulse),
      .last_make(last_make), .seq_timeout(seq_timeout)
   );

   typedef struct packed {
      logic       p1u, p1d, p2u, p2d, st, pa;
      logic [7:0] lm;
   } exp_t;

   exp_t       sb_q[$];
   int         checks = 0, errors = 0;
   bit         held[512];
   bit         m_ext, m_brk;
   logic [7:0] m_last;
   int         exp_timeouts = 0, obs_timeouts = 0, obs_starts = 0;
   bit         mon_en = 1'b0, strobe_seen = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Held keys are indexed by {extended, code}.
   function automatic exp_t model_outs(input bit st, input bit pa);
      exp_t e;
      e.p1u = held[9'h01D] & ~held[9'h01B];
      e.p1d = held[9'h01B] & ~held[9'h01D];
      e.p2u = held[9'h175] & ~held[9'h172];
      e.p2d = held[9'h172] & ~held[9'h175];
      e.st  = st;
      e.pa  = pa;
      e.lm  = m_last;
      return e;
   endfunction

   task automatic model_byte(input logic [7:0] b);
      bit       st = 1'b0, pa = 1'b0;
      logic [8:0] key;
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else begin
         key = {m_ext, b};
         if (!m_brk) begin
            if (key == 9'h029 && !held[key]) st = 1'b1;
            if (key == 9'h04D && !held[key]) pa = 1'b1;
            held[key] = 1'b1;
            m_last    = b;
         end else begin
            held[key] = 1'b0;
         end
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
      sb_q.push_back(model_outs(st, pa));
   endtask

   task automatic model_clear();
      for (int i = 0; i < 512; i++) held[i] = 1'b0;
      m_ext  = 1'b0;
      m_brk  = 1'b0;
      m_last = 8'h00;
   endtask

   task automatic send(input logic [7:0] b);
      scan_code  = b;
      scan_ready = 1'b1;
      model_byte(b);
      @(negedge clk);
      scan_ready = 1'b0;
      scan_code  = 8'($urandom);
   endtask

   task automatic idle(input int k);
      repeat (k) @(negedge clk);
      if (k >= T && (m_ext || m_brk)) begin
         m_ext = 1'b0;
         m_brk = 1'b0;
         exp_timeouts++;
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_p1_up"}, p1_up, 0);
      chk({tag, "_p1_down"}, p1_down, 0);
      chk({tag, "_p2_up"}, p2_up, 0);
      chk({tag, "_p2_down"}, p2_down, 0);
      chk({tag, "_start"}, start_pulse, 0);
      chk({tag, "_pause"}, pause_pulse, 0);
      chk({tag, "_timeout"}, seq_timeout, 0);
      chk({tag, "_last_make"}, last_make, 0);
   endtask

   // Reset for one edge with a byte strobed that must be dropped.
   task automatic do_reset();
      resetn     = 1'b0;
      scan_ready = 1'b1;
      scan_code  = 8'h29;
      @(negedge clk);
      resetn     = 1'b1;
      scan_ready = 1'b0;
      model_clear();
      check_all_zero("mid_reset");
   endtask

   always @(posedge clk) strobe_seen = scan_ready && resetn;

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (seq_timeout === 1'b1) obs_timeouts++;
            if (start_pulse === 1'b1) obs_starts++;
            if (strobe_seen) begin
               if (sb_q.size() == 0) begin
                  chk("sb_underflow", 1, 0);
               end else begin
                  e = sb_q.pop_front();
                  chk("p1_up", p1_up, e.p1u);
                  chk("p1_down", p1_down, e.p1d);
                  chk("p2_up", p2_up, e.p2u);
                  chk("p2_down", p2_down, e.p2d);
                  chk("start_pulse", start_pulse, e.st);
                  chk("pause_pulse", pause_pulse, e.pa);
                  chk("last_make", last_make, e.lm);
               end
            end else begin
               chk("start_idle", start_pulse, 0);
               chk("pause_idle", pause_pulse, 0);
            end
         end
      end
   end

   initial begin
      int s0, t_at;
      int r;
      logic [7:0] b;
      resetn     = 1'b0;
      scan_ready = 1'b0;
      scan_code  = 8'h00;
      model_clear();
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      resetn = 1'b1;
      mon_en = 1'b1;

      // W make then break
      send(8'h1D);
      chk("w_make_p1_up", p1_up, 1);
      idle(2);
      send(8'hF0);
      idle(1);
      send(8'h1D);
      chk("w_break_p1_up", p1_up, 0);
      chk("w_last_make", last_make, 8'h1D);

      // Up, then Up+Down, then release Up
      send(8'hE0); send(8'h75);
      chk("up_p2_up", p2_up, 1);
      send(8'hE0); send(8'h72);
      chk("both_p2_up", p2_up, 0);
      chk("both_p2_down", p2_down, 0);
      send(8'hE0); send(8'hF0); send(8'h75);
      chk("down_p2_down", p2_down, 1);
      send(8'hE0); send(8'hF0); send(8'h72);

      // Space typematic: two fresh presses only
      s0 = obs_starts;
      send(8'h29); idle(1); send(8'h29); idle(1); send(8'h29); idle(1);
      send(8'hF0); send(8'h29); idle(1); send(8'h29); idle(1); send(8'h29);
      idle(2);
      chk("start_pulse_count", obs_starts - s0, 2);
      send(8'hF0); send(8'h29);

      // Abandoned E0: timeout exactly T cycles after the strobe edge
      send(8'hE0);
      t_at = 0;
      for (int i = 1; i <= T + 5; i++) begin
         @(negedge clk);
         if (seq_timeout === 1'b1 && t_at == 0) t_at = i;
      end
      m_ext = 1'b0;
      exp_timeouts++;
      chk("timeout_cycle", t_at, T);
      send(8'h1D);
      chk("after_timeout_plain_w", p1_up, 1);

      // Byte in the expiry cycle is processed, no timeout
      s0 = obs_timeouts;
      send(8'hF0);
      idle(T - 1);
      send(8'h1D);
      chk("expiry_cycle_break", p1_up, 0);
      chk("expiry_cycle_no_tmo", obs_timeouts - s0, 0);

      // Reset in the middle of E0 F0 with W and S held
      send(8'h1D); send(8'h1B);
      chk("ws_p1_up", p1_up, 0);
      chk("ws_p1_down", p1_down, 0);
      send(8'hE0); send(8'hF0);
      do_reset();
      send(8'h75);
      chk("post_reset_p2_up", p2_up, 0);
      chk("post_reset_p2_down", p2_down, 0);
      chk("post_reset_last", last_make, 8'h75);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 11))
            0, 1:    b = 8'hE0;
            2, 3:    b = 8'hF0;
            4:       b = 8'h1D;
            5:       b = 8'h1B;
            6:       b = 8'h29;
            7:       b = 8'h4D;
            8:       b = 8'h75;
            9:       b = 8'h72;
            default: b = 8'($urandom);
         endcase
         send(b);
         r = $urandom_range(0, 39);
         if (r == 0)      idle(T - 1);
         else if (r == 1) idle(T);
         else if (r == 2) idle(T + 1);
         else if (r == 3) do_reset();
         else             idle($urandom_range(0, 4));
      end

      idle(T + 2);
      chk("timeout_count", obs_timeouts, exp_timeouts);
      chk("sb_empty", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
